// File: rtl/mips_pkg.sv
// mips_pkg: constants and helpers shared by the MIPS datapath blocks.
//   DEFAULT_RESET_VECTOR : PC value after reset
//   DEFAULT_EXC_VECTOR   : PC value on exception entry
//   DEFAULT_STEP         : sequential fetch increment in bytes
//   align_mask()         : low-order address mask for a power-of-two granule
package mips_pkg;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h8000_0180;
    localparam int unsigned DEFAULT_STEP         = 4;

    // For a power-of-two step, any address bit under this mask being set
    // means the address is not on a step boundary.
    function automatic int unsigned align_mask(input int unsigned step);
        return step - 1;
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: holds one redirect that arrived while fetch was stalled.
// Ports:
//   i_clock         : system clock
//   i_reset         : synchronous active-high reset (clears the valid flag)
//   i_capture       : latch i_target as the pending redirect
//   i_clear         : drop the pending redirect (consumed or cancelled)
//   i_target        : redirect destination to latch
//   o_pend_valid    : a redirect is waiting
//   o_pend_target   : the waiting redirect destination
module pc_redirect_buf #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_capture,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_target,
    output logic             o_pend_valid,
    output logic [WIDTH-1:0] o_pend_target
);

    logic             r_pend_valid;
    logic [WIDTH-1:0] r_pend_target;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pend_valid <= 1'b0;
        end else if (i_clear) begin
            r_pend_valid <= 1'b0;
        end else if (i_capture) begin
            r_pend_valid <= 1'b1;
        end
    end

    // The target is only meaningful while r_pend_valid is set, so it needs
    // no reset. A newer capture simply overwrites an older one.
    always_ff @(posedge i_clock) begin
        if (i_capture) begin
            r_pend_target <= i_target;
        end
    end

    assign o_pend_valid  = r_pend_valid;
    assign o_pend_target = r_pend_target;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter for the MIPS fetch stage.
// Ports:
//   i_clock              : system clock
//   i_reset              : synchronous active-high reset
//   i_stall              : hold the PC (fetch not accepting)
//   i_redirect_valid     : branch taken / jump this cycle
//   i_redirect_target    : redirect destination
//   i_exception          : exception request (one-cycle pulse)
//   i_eret               : return from exception (one-cycle pulse)
//   o_pc                 : current fetch address (registered)
//   o_pc_next_seq        : o_pc + STEP (combinational)
//   o_epc                : saved exception PC
//   o_badvaddr           : last misaligned redirect target
//   o_addr_err           : one-cycle pulse when a misaligned redirect is trapped
//   o_redirect_pending   : a stalled redirect is waiting for stall release
module pc_unit
    import mips_pkg::*;
#(
    parameter int unsigned       WIDTH        = 32,
    parameter int unsigned       STEP         = DEFAULT_STEP,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_redirect_valid,
    input  logic [WIDTH-1:0] i_redirect_target,
    input  logic             i_exception,
    input  logic             i_eret,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc_next_seq,
    output logic [WIDTH-1:0] o_epc,
    output logic [WIDTH-1:0] o_badvaddr,
    output logic             o_addr_err,
    output logic             o_redirect_pending
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(align_mask(STEP));
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic [WIDTH-1:0] r_badvaddr;
    logic             r_addr_err;

    logic             w_misaligned;
    logic             w_take_exc;
    logic             w_pend_capture;
    logic             w_pend_clear;
    logic             w_pend_valid;
    logic [WIDTH-1:0] w_pend_target;
    logic [WIDTH-1:0] w_pc_seq;
    logic [WIDTH-1:0] w_pc_next;

    // A misaligned redirect is trapped as an address error regardless of
    // stall, exactly like an external exception.
    assign w_misaligned = i_redirect_valid && ((i_redirect_target & ALIGN_MASK) != '0);
    assign w_take_exc   = i_exception || w_misaligned;

    // Only a stalled, otherwise-unclaimed redirect is buffered. Any cycle
    // without stall either consumes the pending target, is beaten by a live
    // redirect, or has nothing pending; exception/eret cancel it.
    assign w_pend_capture = i_stall && i_redirect_valid && !w_take_exc && !i_eret;
    assign w_pend_clear   = w_take_exc || i_eret || !i_stall;

    pc_redirect_buf #(
        .WIDTH (WIDTH)
    ) u_redirect_buf (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_capture     (w_pend_capture),
        .i_clear       (w_pend_clear),
        .i_target      (i_redirect_target),
        .o_pend_valid  (w_pend_valid),
        .o_pend_target (w_pend_target)
    );

    // Wraps modulo 2^WIDTH with no flag.
    assign w_pc_seq = r_pc + STEP_W;

    always_comb begin
        w_pc_next = w_pc_seq;
        if (w_take_exc) begin
            w_pc_next = EXC_VECTOR;
        end else if (i_eret) begin
            w_pc_next = r_epc;
        end else if (i_stall) begin
            w_pc_next = r_pc;
        end else if (i_redirect_valid) begin
            w_pc_next = i_redirect_target;
        end else if (w_pend_valid) begin
            w_pc_next = w_pend_target;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pc       <= RESET_VECTOR;
            r_epc      <= '0;
            r_badvaddr <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_addr_err <= w_misaligned;
            if (w_take_exc) begin
                r_epc <= r_pc;
            end
            if (w_misaligned) begin
                r_badvaddr <= i_redirect_target;
            end
        end
    end

    assign o_pc               = r_pc;
    assign o_pc_next_seq      = w_pc_seq;
    assign o_epc              = r_epc;
    assign o_badvaddr         = r_badvaddr;
    assign o_addr_err         = r_addr_err;
    assign o_redirect_pending = w_pend_valid;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: table-driven scoreboard bench for pc_unit (WIDTH=32 default
// instance) plus a short hand-written wrap/reset sequence on a WIDTH=16
// instance.
module tb_pc_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 32-bit DUT ----------------
    logic        rst, stall, rv, exc, eret;
    logic [31:0] tgt;
    logic [31:0] pc, pc_nseq, epc, bad;
    logic        aerr, pend;

    pc_unit dut (
        .i_clock            (clk),
        .i_reset            (rst),
        .i_stall            (stall),
        .i_redirect_valid   (rv),
        .i_redirect_target  (tgt),
        .i_exception        (exc),
        .i_eret             (eret),
        .o_pc               (pc),
        .o_pc_next_seq      (pc_nseq),
        .o_epc              (epc),
        .o_badvaddr         (bad),
        .o_addr_err         (aerr),
        .o_redirect_pending (pend)
    );

    // ---------------- 16-bit DUT ----------------
    logic        rst16, stall16, rv16, exc16, eret16;
    logic [15:0] tgt16;
    logic [15:0] pc16, nseq16, epc16, bad16;
    logic        aerr16, pend16;

    pc_unit #(
        .WIDTH        (16),
        .STEP         (4),
        .RESET_VECTOR (16'hFFF8),
        .EXC_VECTOR   (16'h0180)
    ) dut16 (
        .i_clock            (clk),
        .i_reset            (rst16),
        .i_stall            (stall16),
        .i_redirect_valid   (rv16),
        .i_redirect_target  (tgt16),
        .i_exception        (exc16),
        .i_eret             (eret16),
        .o_pc               (pc16),
        .o_pc_next_seq      (nseq16),
        .o_epc              (epc16),
        .o_badvaddr         (bad16),
        .o_addr_err         (aerr16),
        .o_redirect_pending (pend16)
    );

    typedef struct {
        logic        rst, stall, rv;
        logic [31:0] tgt;
        logic        exc, eret;
        logic [31:0] pc, epc, bad;
        logic        err, pnd;
    } vec_t;

    typedef struct {
        logic [31:0] pc, epc, bad;
        logic        err, pnd;
        int          row;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(logic r, logic s, logic v, logic [31:0] t,
                                logic e, logic er, logic [31:0] p,
                                logic [31:0] ep, logic [31:0] b,
                                logic ae, logic pn);
        vec_t x;
        x.rst = r; x.stall = s; x.rv = v; x.tgt = t; x.exc = e; x.eret = er;
        x.pc = p; x.epc = ep; x.bad = b; x.err = ae; x.pnd = pn;
        return x;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, req);
        end
    endtask

    initial begin
        exp_t e;
        // rst stall rv tgt exc eret | pc epc bad err pend
        tbl.push_back(mk(1,0,0,32'h0,  0,0, 32'h0,  32'h0, 32'h0, 0,0)); // reset
        tbl.push_back(mk(0,0,0,32'h0,  0,0, 32'h4,  32'h0, 32'h0, 0,0));
        tbl.push_back(mk(0,0,0,32'h0,  0,0, 32'h8,  32'h0, 32'h0, 0,0));
        tbl.push_back(mk(0,0,0,32'h0,  0,0, 32'hC,  32'h0, 32'h0, 0,0));
        tbl.push_back(mk(0,0,0,32'h0,  0,0, 32'h10, 32'h0, 32'h0, 0,0));
        // stall 3 cycles, redirect 0x40 in the 2nd, then release
        tbl.push_back(mk(0,1,0,32'h0,  0,0, 32'h10, 32'h0, 32'h0, 0,0));
        tbl.push_back(mk(0,1,1,32'h40, 0,0, 32'h10, 32'h0, 32'h0, 0,1));
        tbl.push_back(mk(0,1,0,32'h0,  0,0, 32'h10, 32'h0, 32'h0, 0,1));
        tbl.push_back(mk(0,0,0,32'h0,  0,0, 32'h40, 32'h0, 32'h0, 0,0));
        tbl.push_back(mk(0,0,0,32'h0,  0,0, 32'h44, 32'h0, 32'h0, 0,0));
        // pending 0x100, live redirect 0x80 on release wins
        tbl.push_back(mk(0,1,1,32'h100,0,0, 32'h44, 32'h0, 32'h0, 0,1));
        tbl.push_back(mk(0,0,1,32'h80, 0,0, 32'h80, 32'h0, 32'h0, 0,0));
        tbl.push_back(mk(0,0,0,32'h0,  0,0, 32'h84, 32'h0, 32'h0, 0,0));
        // newest stalled redirect overwrites the older one
        tbl.push_back(mk(0,1,1,32'h90, 0,0, 32'h84, 32'h0, 32'h0, 0,1));
        tbl.push_back(mk(0,1,1,32'h94, 0,0, 32'h84, 32'h0, 32'h0, 0,1));
        tbl.push_back(mk(0,0,0,32'h0,  0,0, 32'h94, 32'h0, 32'h0, 0,0));
        // exception at 0x24, then eret
        tbl.push_back(mk(0,0,1,32'h20, 0,0, 32'h20, 32'h0, 32'h0, 0,0));
        tbl.push_back(mk(0,0,0,32'h0,  0,0, 32'h24, 32'h0, 32'h0, 0,0));
        tbl.push_back(mk(0,0,0,32'h0,  1,0, 32'h8000_0180, 32'h24, 32'h0, 0,0));
        tbl.push_back(mk(0,0,0,32'h0,  0,0, 32'h8000_0184, 32'h24, 32'h0, 0,0));
        tbl.push_back(mk(0,0,0,32'h0,  0,1, 32'h24, 32'h24, 32'h0, 0,0));
        tbl.push_back(mk(0,0,0,32'h0,  0,0, 32'h28, 32'h24, 32'h0, 0,0));
        // exception and eret together: exception wins
        tbl.push_back(mk(0,0,0,32'h0,  1,1, 32'h8000_0180, 32'h28, 32'h0, 0,0));
        tbl.push_back(mk(0,0,0,32'h0,  0,1, 32'h28, 32'h28, 32'h0, 0,0));
        tbl.push_back(mk(0,0,0,32'h0,  0,0, 32'h2C, 32'h28, 32'h0, 0,0));
        // misaligned redirect 0x42 -> address error
        tbl.push_back(mk(0,0,1,32'h42, 0,0, 32'h8000_0180, 32'h2C, 32'h42, 1,0));
        tbl.push_back(mk(0,0,0,32'h0,  0,0, 32'h8000_0184, 32'h2C, 32'h42, 0,0));
        // misaligned redirect while stalled still traps
        tbl.push_back(mk(0,1,1,32'h6,  0,0, 32'h8000_0180, 32'h8000_0184, 32'h6, 1,0));
        // exception during stall cancels a pending redirect
        tbl.push_back(mk(0,1,1,32'h200,0,0, 32'h8000_0180, 32'h8000_0184, 32'h6, 0,1));
        tbl.push_back(mk(0,1,0,32'h0,  1,0, 32'h8000_0180, 32'h8000_0180, 32'h6, 0,0));
        tbl.push_back(mk(0,0,0,32'h0,  0,0, 32'h8000_0184, 32'h8000_0180, 32'h6, 0,0));
        // eret ignores stall
        tbl.push_back(mk(0,1,0,32'h0,  0,1, 32'h8000_0180, 32'h8000_0180, 32'h6, 0,0));
        // reset during stall with a pending redirect discards it
        tbl.push_back(mk(0,1,1,32'h300,0,0, 32'h8000_0180, 32'h8000_0180, 32'h6, 0,1));
        tbl.push_back(mk(1,1,0,32'h0,  0,0, 32'h0,  32'h0, 32'h0, 0,0));
        tbl.push_back(mk(0,0,0,32'h0,  0,0, 32'h4,  32'h0, 32'h0, 0,0));

        rst = 1'b1; stall = 1'b0; rv = 1'b0; tgt = '0; exc = 1'b0; eret = 1'b0;
        rst16 = 1'b1; stall16 = 1'b0; rv16 = 1'b0; tgt16 = '0; exc16 = 1'b0; eret16 = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; stall = tbl[i].stall; rv = tbl[i].rv;
            tgt = tbl[i].tgt; exc = tbl[i].exc; eret = tbl[i].eret;
            e.pc = tbl[i].pc; e.epc = tbl[i].epc; e.bad = tbl[i].bad;
            e.err = tbl[i].err; e.pnd = tbl[i].pnd; e.row = i;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                errors++; checks++;
                $display("FAIL scoreboard row %0d: got empty expected entry", i);
            end else begin
                e = sb.pop_front();
                chk("pc",          e.row, pc,      e.pc);
                chk("pc_next_seq", e.row, pc_nseq, e.pc + 32'd4);
                chk("epc",         e.row, epc,     e.epc);
                chk("badvaddr",    e.row, bad,     e.bad);
                chk("addr_err",    e.row, {31'b0, aerr}, {31'b0, e.err});
                chk("pending",     e.row, {31'b0, pend}, {31'b0, e.pnd});
            end
        end

        // 16-bit wrap: reset vector 0xFFF8 -> 0xFFFC -> 0x0000
        @(negedge clk);
        rst16 = 1'b1;
        @(posedge clk); #1;
        chk("w16_reset_pc",   100, {16'b0, pc16},   32'h0000_FFF8);
        chk("w16_reset_nseq", 100, {16'b0, nseq16}, 32'h0000_FFFC);
        chk("w16_reset_epc",  100, {16'b0, epc16},  32'h0);
        @(negedge clk);
        rst16 = 1'b0;
        @(posedge clk); #1;
        chk("w16_pc",   101, {16'b0, pc16},   32'h0000_FFFC);
        chk("w16_nseq", 101, {16'b0, nseq16}, 32'h0000_0000);
        @(posedge clk); #1;
        chk("w16_wrap_pc", 102, {16'b0, pc16}, 32'h0000_0000);
        chk("w16_wrap_err", 102, {31'b0, aerr16}, 32'h0);

        // 16-bit: reset mid-stall with pending redirect
        @(negedge clk);
        stall16 = 1'b1; rv16 = 1'b1; tgt16 = 16'h0400;
        @(posedge clk); #1;
        chk("w16_pend", 103, {31'b0, pend16}, 32'h1);
        chk("w16_hold", 103, {16'b0, pc16},   32'h0);
        @(negedge clk);
        rv16 = 1'b0; rst16 = 1'b1;
        @(posedge clk); #1;
        chk("w16_rst_pc",   104, {16'b0, pc16},   32'h0000_FFF8);
        chk("w16_rst_pend", 104, {31'b0, pend16}, 32'h0);
        @(negedge clk);
        rst16 = 1'b0; stall16 = 1'b0;
        @(posedge clk); #1;
        chk("w16_after_rst", 105, {16'b0, pc16}, 32'h0000_FFFC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS datapath, the successor to the plain PC register. It holds the fetch address and advances it sequentially. It also accepts branch/jump redirects, including ones that arrive while fetch is stalled. It takes exceptions with EPC capture, returns via ERET, and traps misaligned redirect targets. It sits at the head of the fetch stage and feeds the instruction memory address and the PC+step adder result.

## Interface
- WIDTH, 32: address width in bits.
- STEP, 4: sequential increment in bytes; power of two; also the alignment granule.
- RESET_VECTOR, 32'h0000_0000: PC value after reset.
- EXC_VECTOR, 32'h8000_0180: PC value on exception entry.

- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the PC; fetch is not accepting a new address.
- redirect_valid  in  1  branch taken / jump this cycle.
- redirect_target  in  WIDTH  redirect destination.
- exception  in  1  external exception request (one-cycle pulse).
- eret  in  1  return from exception (one-cycle pulse).
- pc  out  WIDTH  current fetch address (registered).
- pc_next_seq  out  WIDTH  pc + STEP, combinational.
- epc  out  WIDTH  saved exception PC (registered).
- badvaddr  out  WIDTH  last misaligned redirect target (registered).
- addr_err  out  1  one-cycle pulse: misaligned redirect trapped.
- redirect_pending  out  1  a redirect is latched and waiting on stall release.

## Operation
- Internal state: pc, epc, badvaddr, pend_valid, pend_target, addr_err.
- Misaligned condition: redirect_valid && (redirect_target mod STEP) != 0. Treated as an address-error exception.
- Per-cycle priority, highest first:
  1. reset: pc <= RESET_VECTOR, epc <= 0, badvaddr <= 0, pend_valid <= 0, addr_err <= 0.
  2. exception or misaligned redirect: epc <= pc, pc <= EXC_VECTOR, pend_valid <= 0. Ignores stall. Misaligned case additionally sets badvaddr <= redirect_target and addr_err <= 1.
  3. eret: pc <= epc, pend_valid <= 0. Ignores stall.
  4. stall=1:
     - pc holds.
     - If redirect_valid: pend_valid <= 1, pend_target <= redirect_target. The newest redirect overwrites any older pending one.
  5. stall=0 with redirect_valid: pc <= redirect_target, pend_valid <= 0. A live redirect beats a pending one.
  6. stall=0 with pend_valid: pc <= pend_target, pend_valid <= 0.
  7. Otherwise: pc <= pc + STEP.
- addr_err is 0 in every cycle not covered by rule 2.
- Arithmetic is modulo 2^WIDTH. pc = 2^WIDTH − STEP advances to 0 with no flag.
- exception and eret in the same cycle: exception wins.
- redirect_pending = pend_valid.

## Timing
- All outputs are registered, except pc_next_seq, which is combinational from pc.
- Redirect, exception and eret take effect on the following edge: latency 1.
- A pending redirect applies on the first edge with stall=0: latency 1 after stall drops.
- Reset values:
  - pc = RESET_VECTOR
  - epc = 0
  - badvaddr = 0
  - addr_err = 0
  - redirect_pending = 0
  - pc_next_seq = RESET_VECTOR + STEP
- Reset asserted mid-stall with a pending redirect discards the pending redirect.

## Structure
- Shared package `mips_pkg`: default vector constants, and the STEP/alignment helper function.
- One sub-module is natural: `pc_redirect_buf`, holding the pend_valid/pend_target capture and clear logic.
- Target size: about 150–250 lines of RTL.

## Test plan
- Reset then 4 free-running cycles -> pc = 0, 4, 8, 12, 16; pc_next_seq always pc + 4.
- stall=1 at pc=0x10 for 3 cycles with redirect to 0x40 in the 2nd cycle, then release -> pc stays 0x10 with redirect_pending=1, then pc = 0x40, 0x44.
- Pending 0x40, then a live redirect 0x80 in the release cycle -> pc = 0x80; pending cleared.
- exception at pc=0x24 -> pc = 0x8000_0180, epc = 0x24; later eret -> pc = 0x24, then 0x28.
- Redirect to 0x42 -> addr_err=1 for exactly one cycle, badvaddr = 0x42, pc = 0x8000_0180, epc = faulting-cycle pc.
- WIDTH=16, pc=0xFFFC -> next pc = 0x0000; reset asserted during a stall with a pending redirect -> pc = RESET_VECTOR, redirect_pending = 0.
